// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter.
// Handles one digit per cycle, most significant digit first, using acc = acc*10 + digit.
module bcd_to_bin #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      binary,
  output logic                  err
);

  localparam int unsigned CntW = $clog2(DIGITS + 1);
  localparam int unsigned AccW = BIN_W + 4;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StDone
  } state_t;

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [AccW-1:0]     acc_q, acc_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                busy_d, done_d, err_d;
  logic [BIN_W-1:0]    binary_d;

  logic                bad_digit;
  logic [3:0]          top_nibble;
  logic [AccW-1:0]     acc_next;

  always_comb begin
    bad_digit = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) begin
        bad_digit = 1'b1;
      end
    end
  end

  // acc*10 built from shifts; AccW leaves headroom for the intermediate sum.
  assign top_nibble = digits_q[4*DIGITS-1 -: 4];
  assign acc_next   = (acc_q << 3) + (acc_q << 1) + {{(AccW-4){1'b0}}, top_nibble};

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy;
    done_d   = 1'b0;
    err_d    = err;
    binary_d = binary;

    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (start) begin
          busy_d = 1'b1;
          if (bad_digit) begin
            err_d    = 1'b1;
            binary_d = '0;
            done_d   = 1'b1;
            state_d  = StDone;
          end else begin
            digits_d = bcd_in;
            acc_d    = '0;
            cnt_d    = CntW'(DIGITS);
            err_d    = 1'b0;
            state_d  = StConv;
          end
        end
      end
      StConv: begin
        busy_d   = 1'b1;
        acc_d    = acc_next;
        digits_d = digits_q << 4;
        cnt_d    = cnt_q - CntW'(1);
        // Last digit: publish the freshly computed value directly.
        if (cnt_q == CntW'(1)) begin
          binary_d = acc_next[BIN_W-1:0];
          done_d   = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      digits_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      binary   <= '0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      binary   <= binary_d;
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed vector table plus hand-written corner sequences.
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] bcd_in;
  logic        busy, done, err;
  logic [9:0]  binary;

  logic        start4;
  logic [15:0] bcd4;
  logic        busy4, done4, err4;
  logic [13:0] binary4;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bcd_to_bin dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bcd_in (bcd_in),
    .busy   (busy),
    .done   (done),
    .binary (binary),
    .err    (err)
  );

  bcd_to_bin #(
    .DIGITS (4),
    .BIN_W  (14)
  ) dut4 (
    .clk    (clk),
    .rst    (rst),
    .start  (start4),
    .bcd_in (bcd4),
    .busy   (busy4),
    .done   (done4),
    .binary (binary4),
    .err    (err4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] bcd;
    logic [9:0]  bin;
    logic        err;
  } vec_t;

  vec_t vecs[9];
  int   dcyc[9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Accepts v at the next edge, waits for done, checks latency/result, then the idle cycle.
  task automatic run_vec(input string name, input logic [11:0] v, input logic [9:0] eb,
                         input logic ee, output int done_at);
    int   n;
    logic busy_ok;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = v;
    @(posedge clk);
    #1;
    start  = 1'b0;
    bcd_in = 12'hFFF;
    n       = 0;
    busy_ok = 1'b1;
    while (!done && n < 12) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    done_at = cyc;
    check($sformatf("%s latency", name), n, ee ? 0 : 3);
    check($sformatf("%s busy", name), int'(busy_ok & busy), 1);
    check($sformatf("%s binary", name), int'(binary), int'(eb));
    check($sformatf("%s err", name), int'(err), int'(ee));
    @(posedge clk);
    #1;
    check($sformatf("%s idle busy/done", name), int'({busy, done}), 0);
    check($sformatf("%s held binary", name), int'(binary), int'(eb));
    check($sformatf("%s held err", name), int'(err), int'(ee));
  endtask

  initial begin
    int   n, t1, t2, dummy;
    logic saw_done;

    vecs[0] = '{12'h999, 10'd999, 1'b0};
    vecs[1] = '{12'h000, 10'd0,   1'b0};
    vecs[2] = '{12'h005, 10'd5,   1'b0};
    vecs[3] = '{12'h1A3, 10'd0,   1'b1};
    vecs[4] = '{12'h123, 10'd123, 1'b0};
    vecs[5] = '{12'h500, 10'd500, 1'b0};
    vecs[6] = '{12'h0F0, 10'd0,   1'b1};
    vecs[7] = '{12'h099, 10'd99,  1'b0};
    vecs[8] = '{12'h980, 10'd980, 1'b0};

    rst    = 1'b1;
    start  = 1'b0;
    bcd_in = 12'h0;
    start4 = 1'b0;
    bcd4   = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", int'({busy, done, err, binary}), 0);
    check("reset outputs d4", int'({busy4, done4, err4, binary4}), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].bin, vecs[i].err, dcyc[i]);
    end
    check("back-to-back done gap", dcyc[2] - dcyc[1], 5);

    // start held high through CONV/DONE with a different input must not disturb 456.
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h456;
    @(posedge clk);
    #1;
    bcd_in = 12'h789;
    n = 0;
    while (!done && n < 12) begin
      @(posedge clk);
      #1;
      n++;
    end
    t1 = cyc;
    check("held-start first latency", n, 3);
    check("held-start first binary", int'(binary), 456);
    @(posedge clk);
    #1;
    check("held-start no queued done", int'(done), 0);
    n = 0;
    while (!done && n < 12) begin
      @(posedge clk);
      #1;
      n++;
    end
    t2 = cyc;
    start = 1'b0;
    check("held-start second binary", int'(binary), 789);
    check("held-start done gap", t2 - t1, 5);

    // Reset on the second CONV edge aborts with no done pulse.
    @(posedge clk);
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h888;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid-conv reset outputs", int'({busy, done, err, binary}), 0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    check("no done after abort", int'(saw_done), 0);
    run_vec("post-reset", 12'h123, 10'd123, 1'b0, dummy);

    // Four-digit instance.
    @(negedge clk);
    start4 = 1'b1;
    bcd4   = 16'h9999;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    bcd4   = 16'h0000;
    n = 0;
    while (!done4 && n < 12) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("d4 latency", n, 4);
    check("d4 binary", int'(binary4), 9999);
    check("d4 err", int'(err4), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
